midi_voice_alloc: RTL and testbench
===================================

# midi_voice_alloc

Consumes the received MIDI byte stream (`rx_data`/`rx_valid` from the MIDI UART receiver) and turns Note On/Off messages on one channel into per-voice gate/note/velocity state for the synth voice bank. Contains a byte-level message parser with running status and a voice allocator that shares `NVOICES` voices among incoming notes, stealing the oldest voice when all are busy. Sits between the MIDI receiver and the oscillator/envelope voices.

## Interface

- `NVOICES`, 4: number of voices, 2..8.
- `CHANNEL`, 0: MIDI channel accepted, 0..15.
- `OMNI`, 0: 1 means accept all channels and ignore `CHANNEL`.

- `clk_50m`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_data`  in  8  received byte, qualified by `rx_valid`.
- `rx_valid`  in  1  one-cycle strobe per byte; may be asserted every cycle.
- `voice_gate`  out  NVOICES  bit v high while voice v holds a note.
- `voice_note`  out  7*NVOICES  note number of voice v at bits [7v+6:7v].
- `voice_vel`  out  7*NVOICES  velocity of voice v, same packing.
- `voice_trig`  out  NVOICES  one-cycle pulse when voice v is (re)assigned a note.

## Operation

**Parser.** States are P_IDLE (no running status), P_D1 (await data 1) and P_D2 (await data 2). It keeps a latched status type: NOTEON, NOTEOFF, CC, SKIP1 or SKIP2.

- Bytes 0xF8–0xFF (realtime) are ignored with no effect on state or latched data.
- Bytes 0xF0–0xF7 clear running status and go to P_IDLE.
- Byte 0x8n / 0x9n / 0xBn with the channel matching sets NOTEOFF / NOTEON / CC and goes to P_D1.
- Byte 0xCn / 0xDn on any channel, or any channel-voice status on a non-matching channel, sets SKIP1 (Cn/Dn) or SKIP2 (others) and goes to P_D1.
- Data byte (bit 7 = 0) handling:
  - In P_IDLE: discarded.
  - In P_D1: latch as d1. SKIP1 returns to P_D1; all other types go to P_D2.
  - In P_D2: the message is complete and the parser returns to P_D1 (running status).
- On completion the parser registers one event:
  - NOTEON with d2 ≠ 0 → ON.
  - NOTEON with d2 = 0, or NOTEOFF → OFF.
  - CC with d1 = 0x7B → ALLOFF.
  - Anything else → no event.

**Allocator.** Processes at most one event per cycle.

- Each voice has an age rank 0..NVOICES-1. The ranks always form a permutation, with 0 = most recently assigned.
- ON, in priority order:
  1. A gated voice already holding the same note is retriggered (velocity updated).
  2. Otherwise the lowest-index voice with gate = 0 is used.
  3. Otherwise the voice with rank NVOICES-1 is stolen.
- On any ON assignment:
  - The chosen voice's gate goes to 1, note and velocity are loaded, and its trig pulses.
  - The chosen voice's rank becomes 0.
  - Every voice whose rank was below the chosen voice's old rank increments its rank.
- OFF clears the gate of the gated voice whose note matches. Note and velocity are retained for release. If no voice matches, nothing happens.
- ALLOFF clears all gates. Notes, velocities and ranks are unchanged.

**Reset values.**
- Parser: P_IDLE, type SKIP2.
- Outputs: all gates, notes, velocities and trigs are 0.
- Ranks: voice v has rank v.

## Timing

- The byte completing a message is accepted at edge t (rx_valid high in the cycle before t).
- The parser event register is loaded at edge t.
- Voice outputs and `voice_trig` update at edge t+1.
- Fixed latency of 2 clock edges from the `rx_valid` cycle; `voice_trig` is high for exactly 1 cycle.
- Back-to-back bytes every cycle are accepted without loss; the event pipeline holds one event and drains every cycle.
- A realtime byte in the middle of a message does not alter state or latency.
- Reset mid-message discards the partial message and the running status. A data byte arriving right after reset is discarded.
- No backpressure. Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- Send 90 3C 64 → two edges after the last `rx_valid`: gate[0]=1, note0=0x3C, vel0=0x64, trig = 0001 for 1 cycle. All other voices unchanged.
- Running status: send 90 3C 64 40 50 → voice1 gets 0x40/0x50. Then send 3C 00 → gate[0]=0, note0 remains 0x3C.
- Steal with NVOICES=4: send 90 3C 64 3E 64 40 64 41 64 43 64 → voices 0–3 take 3C/3E/40/41, then 43 goes to voice0 with trig=0001. A sixth note 45 goes to voice1.
- Filtering: send 90 F8 3C FE 64 → same result as the first test. Then 91 3C 64 → no change. Then F0 3E 64 → no change (running status cleared).
- Retrigger and all-off: 90 3C 64, then 3C 20 → voice0 retriggered with vel 0x20 and no other voice used. Then B0 7B 00 → all gates 0.
- Reset mid-message: send 90 3C, pulse `rst_n` low, then send 64 → no event. All outputs stay at reset values; ranks are 0,1,2,3.

Source files
------------

// File: rtl/midi_voice_alloc_if.sv
// MIDI byte input and per-voice state bundle between the receiver, the voice
// allocator and the voice bank.
interface midi_voice_alloc_if #(
  parameter int NVOICES = 4
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic [NVOICES-1:0]   voice_gate;
  logic [7*NVOICES-1:0] voice_note;
  logic [7*NVOICES-1:0] voice_vel;
  logic [NVOICES-1:0]   voice_trig;

  modport master (
    output rx_data, rx_valid,
    input  voice_gate, voice_note, voice_vel, voice_trig
  );

  modport slave (
    input  rx_data, rx_valid,
    output voice_gate, voice_note, voice_vel, voice_trig
  );
endinterface

// File: rtl/midi_voice_alloc.sv
// MIDI Note On/Off parser with running status feeding an oldest-steal voice allocator.
// Voice state updates 2 edges after the completing byte; no backpressure, a byte may arrive every cycle.
module midi_voice_alloc #(
  parameter int NVOICES = 4,
  parameter int CHANNEL = 0,
  parameter int OMNI    = 0
) (
  input  logic              clk_50m,
  input  logic              rst_n,
  midi_voice_alloc_if.slave bus
);

  localparam int RW = $clog2(NVOICES);

  typedef enum logic [1:0] {P_IDLE, P_D1, P_D2} pstate_e;
  typedef enum logic [2:0] {T_NOTEON, T_NOTEOFF, T_CC, T_SKIP1, T_SKIP2} mtype_e;
  typedef enum logic [1:0] {EV_NONE, EV_ON, EV_OFF, EV_ALLOFF} ev_e;

  pstate_e    p_state_q, p_state_d;
  mtype_e     type_q, type_d;
  logic [6:0] d1_q, d1_d;
  ev_e        ev_q, ev_d;
  logic [6:0] ev_note_q, ev_note_d;
  logic [6:0] ev_vel_q, ev_vel_d;

  logic [NVOICES-1:0] gate_q, gate_d;
  logic [NVOICES-1:0] trig_q, trig_d;
  logic [6:0]         note_q [NVOICES];
  logic [6:0]         note_d [NVOICES];
  logic [6:0]         vel_q  [NVOICES];
  logic [6:0]         vel_d  [NVOICES];
  logic [RW-1:0]      rank_q [NVOICES];
  logic [RW-1:0]      rank_d [NVOICES];

  logic          chan_ok;
  logic          hit, free;
  logic [RW-1:0] hit_idx, free_idx, old_idx, chosen;

  assign chan_ok = (OMNI != 0) || (bus.rx_data[3:0] == 4'(CHANNEL));

  // Byte-level parser; the event register is rewritten every cycle so it drains on its own.
  always_comb begin
    p_state_d = p_state_q;
    type_d    = type_q;
    d1_d      = d1_q;
    ev_d      = EV_NONE;
    ev_note_d = ev_note_q;
    ev_vel_d  = ev_vel_q;
    if (bus.rx_valid) begin
      if (bus.rx_data[7:3] == 5'b11111) begin
        p_state_d = p_state_q;
      end else if (bus.rx_data[7:4] == 4'hF) begin
        p_state_d = P_IDLE;
      end else if (bus.rx_data[7]) begin
        p_state_d = P_D1;
        case (bus.rx_data[7:4])
          4'h8:    type_d = chan_ok ? T_NOTEOFF : T_SKIP2;
          4'h9:    type_d = chan_ok ? T_NOTEON  : T_SKIP2;
          4'hB:    type_d = chan_ok ? T_CC      : T_SKIP2;
          4'hC,
          4'hD:    type_d = T_SKIP1;
          default: type_d = T_SKIP2;
        endcase
      end else begin
        case (p_state_q)
          P_D1: begin
            d1_d      = bus.rx_data[6:0];
            p_state_d = (type_q == T_SKIP1) ? P_D1 : P_D2;
          end
          P_D2: begin
            p_state_d = P_D1;
            ev_note_d = d1_q;
            ev_vel_d  = bus.rx_data[6:0];
            case (type_q)
              T_NOTEON:  ev_d = (bus.rx_data[6:0] != 7'd0) ? EV_ON : EV_OFF;
              T_NOTEOFF: ev_d = EV_OFF;
              T_CC:      ev_d = (d1_q == 7'h7B) ? EV_ALLOFF : EV_NONE;
              default:   ev_d = EV_NONE;
            endcase
          end
          default: p_state_d = p_state_q;
        endcase
      end
    end
  end

  // Descending scan so the lowest-index match/free voice wins.
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    old_idx  = '0;
    for (int v = NVOICES - 1; v >= 0; v--) begin
      if (gate_q[v] && (note_q[v] == ev_note_q)) begin
        hit     = 1'b1;
        hit_idx = RW'(v);
      end
      if (!gate_q[v]) begin
        free     = 1'b1;
        free_idx = RW'(v);
      end
      if (rank_q[v] == RW'(NVOICES - 1)) old_idx = RW'(v);
    end
    chosen = hit ? hit_idx : (free ? free_idx : old_idx);
  end

  always_comb begin
    gate_d = gate_q;
    note_d = note_q;
    vel_d  = vel_q;
    rank_d = rank_q;
    trig_d = '0;
    case (ev_q)
      EV_ON: begin
        for (int v = 0; v < NVOICES; v++) begin
          if (RW'(v) == chosen) begin
            gate_d[v] = 1'b1;
            note_d[v] = ev_note_q;
            vel_d[v]  = ev_vel_q;
            trig_d[v] = 1'b1;
            rank_d[v] = '0;
          end else if (rank_q[v] < rank_q[chosen]) begin
            rank_d[v] = rank_q[v] + RW'(1);
          end
        end
      end
      EV_OFF: begin
        for (int v = 0; v < NVOICES; v++) begin
          if (gate_q[v] && (note_q[v] == ev_note_q)) gate_d[v] = 1'b0;
        end
      end
      EV_ALLOFF: gate_d = '0;
      default:   gate_d = gate_q;
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      p_state_q <= P_IDLE;
      type_q    <= T_SKIP2;
      d1_q      <= '0;
      ev_q      <= EV_NONE;
      ev_note_q <= '0;
      ev_vel_q  <= '0;
      gate_q    <= '0;
      trig_q    <= '0;
      for (int v = 0; v < NVOICES; v++) begin
        note_q[v] <= '0;
        vel_q[v]  <= '0;
        rank_q[v] <= RW'(v);
      end
    end else begin
      p_state_q <= p_state_d;
      type_q    <= type_d;
      d1_q      <= d1_d;
      ev_q      <= ev_d;
      ev_note_q <= ev_note_d;
      ev_vel_q  <= ev_vel_d;
      gate_q    <= gate_d;
      trig_q    <= trig_d;
      note_q    <= note_d;
      vel_q     <= vel_d;
      rank_q    <= rank_d;
    end
  end

  assign bus.voice_gate = gate_q;
  assign bus.voice_trig = trig_q;

  for (genvar g = 0; g < NVOICES; g++) begin : g_out
    assign bus.voice_note[7*g +: 7] = note_q[g];
    assign bus.voice_vel[7*g +: 7]  = vel_q[g];
  end

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Directed bench for midi_voice_alloc: byte sequences with hand-computed voice state.
module tb_midi_voice_alloc;

  logic clk_50m = 1'b0;
  logic rst_n   = 1'b0;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   fail_cnt  = 0;

  always #10 clk_50m = ~clk_50m;

  midi_voice_alloc_if #(.NVOICES(4)) bus ();

  midi_voice_alloc #(.NVOICES(4), .CHANNEL(0), .OMNI(0)) dut (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk_50m);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk_50m);
    bus.rx_valid = 1'b0;
  endtask

  // Drop valid, then wait until the allocator edge has passed.
  task automatic settle();
    idle();
    @(negedge clk_50m);
  endtask

  task automatic do_reset();
    @(negedge clk_50m);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    do_reset();
    @(negedge clk_50m);
    chk("rst_gate", bus.voice_gate, 4'b0000);
    chk("rst_note", bus.voice_note, 28'h0);
    chk("rst_vel",  bus.voice_vel,  28'h0);
    chk("rst_trig", bus.voice_trig, 4'b0000);

    // Single note on
    send(8'h90); send(8'h3C); send(8'h64);
    idle();
    chk("t1_latency_gate", bus.voice_gate, 4'b0000);
    @(negedge clk_50m);
    chk("t1_gate", bus.voice_gate, 4'b0001);
    chk("t1_note", bus.voice_note, {7'h0, 7'h0, 7'h0, 7'h3C});
    chk("t1_vel",  bus.voice_vel,  {7'h0, 7'h0, 7'h0, 7'h64});
    chk("t1_trig", bus.voice_trig, 4'b0001);
    @(negedge clk_50m);
    chk("t1_trig_pulse", bus.voice_trig, 4'b0000);

    // Running status
    send(8'h40); send(8'h50);
    settle();
    chk("t2_gate", bus.voice_gate, 4'b0011);
    chk("t2_note", bus.voice_note, {7'h0, 7'h0, 7'h40, 7'h3C});
    chk("t2_vel",  bus.voice_vel,  {7'h0, 7'h0, 7'h50, 7'h64});
    chk("t2_trig", bus.voice_trig, 4'b0010);
    send(8'h3C); send(8'h00);
    settle();
    chk("t2_off_gate", bus.voice_gate, 4'b0010);
    chk("t2_off_note", bus.voice_note, {7'h0, 7'h0, 7'h40, 7'h3C});
    chk("t2_off_trig", bus.voice_trig, 4'b0000);

    // Voice stealing
    do_reset();
    send(8'h90);
    send(8'h3C); send(8'h64); send(8'h3E); send(8'h64);
    send(8'h40); send(8'h64); send(8'h41); send(8'h64);
    send(8'h43); send(8'h64);
    settle();
    chk("t3_gate", bus.voice_gate, 4'b1111);
    chk("t3_note", bus.voice_note, {7'h41, 7'h40, 7'h3E, 7'h43});
    chk("t3_trig", bus.voice_trig, 4'b0001);
    send(8'h45); send(8'h64);
    settle();
    chk("t3_steal2_note", bus.voice_note, {7'h41, 7'h40, 7'h45, 7'h43});
    chk("t3_steal2_trig", bus.voice_trig, 4'b0010);

    // Realtime bytes and channel/system filtering
    do_reset();
    send(8'h90); send(8'hF8); send(8'h3C); send(8'hFE); send(8'h64);
    settle();
    chk("t4_rt_gate", bus.voice_gate, 4'b0001);
    chk("t4_rt_note", bus.voice_note, {7'h0, 7'h0, 7'h0, 7'h3C});
    chk("t4_rt_vel",  bus.voice_vel,  {7'h0, 7'h0, 7'h0, 7'h64});
    chk("t4_rt_trig", bus.voice_trig, 4'b0001);
    send(8'h91); send(8'h3C); send(8'h64);
    settle();
    chk("t4_ch1_gate", bus.voice_gate, 4'b0001);
    chk("t4_ch1_trig", bus.voice_trig, 4'b0000);
    send(8'hF0); send(8'h3E); send(8'h64);
    settle();
    chk("t4_sys_gate", bus.voice_gate, 4'b0001);
    chk("t4_sys_note", bus.voice_note, {7'h0, 7'h0, 7'h0, 7'h3C});
    chk("t4_sys_trig", bus.voice_trig, 4'b0000);

    // Retrigger, all-off, note-off handling
    do_reset();
    send(8'h90); send(8'h3C); send(8'h64); send(8'h3E); send(8'h30);
    settle();
    chk("t5_two_gate", bus.voice_gate, 4'b0011);
    send(8'h3C); send(8'h20);
    settle();
    chk("t5_retrig_gate", bus.voice_gate, 4'b0011);
    chk("t5_retrig_vel",  bus.voice_vel,  {7'h0, 7'h0, 7'h30, 7'h20});
    chk("t5_retrig_trig", bus.voice_trig, 4'b0001);
    send(8'hB0); send(8'h7B); send(8'h00);
    settle();
    chk("t5_alloff_gate", bus.voice_gate, 4'b0000);
    chk("t5_alloff_note", bus.voice_note, {7'h0, 7'h0, 7'h3E, 7'h3C});
    send(8'h90); send(8'h50); send(8'h10);
    settle();
    chk("t5_reuse_trig", bus.voice_trig, 4'b0001);
    chk("t5_reuse_note", bus.voice_note, {7'h0, 7'h0, 7'h3E, 7'h50});
    send(8'h80); send(8'h55); send(8'h00);
    settle();
    chk("t5_off_nomatch", bus.voice_gate, 4'b0001);
    send(8'h80); send(8'h50); send(8'h40);
    settle();
    chk("t5_off_gate", bus.voice_gate, 4'b0000);
    chk("t5_off_note", bus.voice_note, {7'h0, 7'h0, 7'h3E, 7'h50});

    // Reset in the middle of a message
    do_reset();
    send(8'h90); send(8'h3C);
    @(negedge clk_50m);
    bus.rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_50m);
    rst_n = 1'b1;
    send(8'h64);
    settle();
    @(negedge clk_50m);
    chk("t6_gate", bus.voice_gate, 4'b0000);
    chk("t6_note", bus.voice_note, 28'h0);
    chk("t6_vel",  bus.voice_vel,  28'h0);
    chk("t6_trig", bus.voice_trig, 4'b0000);
    send(8'h90);
    send(8'h01); send(8'h01); send(8'h02); send(8'h01);
    send(8'h03); send(8'h01); send(8'h04); send(8'h01);
    send(8'h05); send(8'h01);
    settle();
    chk("t6_rank_steal_trig", bus.voice_trig, 4'b0001);
    chk("t6_rank_steal_note", bus.voice_note, {7'h04, 7'h03, 7'h02, 7'h05});

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
